fifo_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter sharing one FIFO (DEPTH x DATA_WIDTH, single clock) among NREQ producers.

---
 rtl/fifo_arb_pkg.sv | 5 +
 rtl/rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  localparam int STAT_W = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search, first set request at or after ptr_i, wrapping to the lowest
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  logic          hi;
  logic [IW-1:0] hi_idx, lo_idx;
  // lowest request overall (wrap case) and lowest request at or above the pointer
  always_comb begin
    hi = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_i[j]) lo_idx = IW'(j);
      if (req_i[j] && IW'(j) >= ptr_i) begin
        hi = 1'b1;
        hi_idx = IW'(j);
      end
    end
  end
  assign found_o = |req_i;
  assign idx_o = hi ? hi_idx : lo_idx;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port; FIFO_ARB_STATS_EN adds beat/stall counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wren,
  output logic [DATA_WIDTH-1:0]      fifo_wdata,
  output logic                       grant_vld,
  output logic [$clog2(NREQ)-1:0]    grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]          stat_beats,
  output logic [STAT_W-1:0]          stat_stall
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  arb_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, pick_idx;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          pick_found, in_burst, g_valid, burst_end;

  rr_pick #(.N(NREQ)) u_pick (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  assign in_burst   = state_q == ARB_BURST;
  assign g_valid    = req_valid[grant_id_q];
  assign req_ready  = (in_burst && !fifo_full) ? NREQ'(1) << grant_id_q : '0;
  assign fifo_wren  = in_burst && g_valid && !fifo_full;
  assign fifo_wdata = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_vld  = in_burst;
  assign grant_id   = grant_id_q;
  // a non-full cycle closes the burst on its last beat or when the grantee has nothing to send
  assign burst_end  = in_burst && !fifo_full && (!g_valid || beat_cnt_q == CW'(BURST_LEN - 1));

  // next state: grant from IDLE, count beats, release and rotate priority past the grantee
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    if (!in_burst && pick_found) begin
      state_d = ARB_BURST;
      grant_id_d = pick_idx;
      beat_cnt_d = '0;
    end
    if (fifo_wren) beat_cnt_d = beat_cnt_q + 1'b1;
    if (burst_end) begin
      state_d = ARB_IDLE;
      rr_ptr_d = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    end
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] beats_q, stall_q;
  // free-running counters of written beats and of grantee cycles blocked by a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      if (fifo_wren) beats_q <= beats_q + 1'b1;
      if (in_burst && g_valid && fifo_full) stall_q <= stall_q + 1'b1;
    end
  end
  assign stat_beats = beats_q;
  assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench with a transaction-level arbiter model, a depth-8 FIFO and queue-driven producers
module tb_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, BL = 4, DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0, rd_en = 1'b0, fifo_full = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic fifo_wren, grant_vld;
  logic [DW-1:0] fifo_wdata;
  logic [1:0] grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [31:0] stat_beats, stat_stall;
`endif
  logic [7:0] src [N][$];
  logic [7:0] fq[$], wr_log[$];
  int wr_cyc[$], wr_gid[$];
  int cyc = 0, checks = 0, errors = 0;
  bit m_busy = 0;
  int m_owner = 0, m_beats = 0, m_ptr = 0, m_tot = 0, m_stall = 0;

  fifo_wr_arbiter #(.NREQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata),
    .grant_vld(grant_vld), .grant_id(grant_id)
`ifdef FIFO_ARB_STATS_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model, FIFO and producers all advance on the clock edge from pre-edge values
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_tot = 0; m_stall = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++)
        if (!m_busy && req_valid[(m_ptr + k) % N]) begin
          m_busy = 1; m_owner = (m_ptr + k) % N; m_beats = 0;
        end
    end else if (fifo_full) begin
      if (req_valid[m_owner]) m_stall++;
    end else if (req_valid[m_owner]) begin
      m_beats++; m_tot++;
      if (m_beats == BL) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
    end else begin
      m_busy = 0; m_ptr = (m_owner + 1) % N;
    end
    if (rd_en && fq.size() > 0) void'(fq.pop_front());
    if (fifo_wren) begin
      fq.push_back(fifo_wdata); wr_log.push_back(fifo_wdata);
      wr_cyc.push_back(cyc); wr_gid.push_back(int'(grant_id));
    end
    fifo_full <= fq.size() >= DEPTH;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) void'(src[i].pop_front());
      req_valid[i] <= src[i].size() > 0;
      req_data[i*DW +: DW] <= src[i].size() > 0 ? src[i][0] : 8'h00;
    end
  end

  // every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_wren", 32'(fifo_wren), 0);
      chk("rst_gvld", 32'(grant_vld), 0);
      chk("rst_gid", 32'(grant_id), 0);
`ifdef FIFO_ARB_STATS_EN
      chk("rst_stat_beats", stat_beats, 0);
      chk("rst_stat_stall", stat_stall, 0);
`endif
    end else begin
      chk("grant_vld", 32'(grant_vld), 32'(m_busy));
      if (m_busy) chk("grant_id", 32'(grant_id), m_owner);
      chk("req_ready", 32'(req_ready), (m_busy && !fifo_full) ? (1 << m_owner) : 0);
      chk("fifo_wren", 32'(fifo_wren), 32'(m_busy && !fifo_full && src[m_owner].size() > 0));
      if (m_busy && !fifo_full && src[m_owner].size() > 0) chk("fifo_wdata", 32'(fifo_wdata), 32'(src[m_owner][0]));
      if (fifo_full) chk("wren_when_full", 32'(fifo_wren), 0);
      chk("ready_onehot0", 32'($countones(req_ready) <= 1), 1);
`ifdef FIFO_ARB_STATS_EN
      chk("stat_beats", stat_beats, m_tot);
      chk("stat_stall", stat_stall, m_stall);
`endif
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_writes(int n, string name);
    int b = 0;
    while (wr_log.size() < n && b < 200) begin step(1); b++; end
    checks++;
    if (wr_log.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d writes, required %0d", name, wr_log.size(), n);
    end
  endtask

  task automatic clear();
    wr_log.delete(); wr_cyc.delete(); wr_gid.delete(); fq.delete();
    step(1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic chk_log(string name, int i, int data, int gid);
    if (i < wr_log.size()) begin
      chk(name, 32'(wr_log[i]), data);
      chk({name, "_gid"}, wr_gid[i], gid);
    end else chk({name, "_missing"}, i, 32'(wr_log.size()));
  endtask

  initial begin
    step(3);
    chk("init_gvld", 32'(grant_vld), 0);
    chk("init_wren", 32'(fifo_wren), 0);
    chk("init_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    // single requester: two bursts separated by an arbitration bubble
    clear();
    for (int b = 0; b < 6; b++) src[2].push_back(8'(8'h10 + b));
    wait_writes(6, "t2");
    step(3);
    for (int i = 0; i < 6; i++) chk_log("t2_data", i, 8'h10 + i, 2);
    if (wr_cyc.size() >= 6) begin
      chk("t2_burst_span", wr_cyc[3] - wr_cyc[0], 3);
      chk("t2_bubble", wr_cyc[4] - wr_cyc[3], 2);
    end
    // reset mid-burst drops outputs before the next edge
    clear();
    for (int b = 0; b < 8; b++) src[3].push_back(8'(8'h30 + b));
    wait_writes(2, "t1");
    chk_log("t1_data", 0, 8'h30, 3);
    chk("t1_wren_before", 32'(fifo_wren), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_ready", 32'(req_ready), 0);
    chk("t1_wren", 32'(fifo_wren), 0);
    chk("t1_gvld", 32'(grant_vld), 0);
    chk("t1_gid", 32'(grant_id), 0);
    src[3].delete();
    step(2);
    rst_n = 1'b1;
    // all requesters valid: strict rotation from req 0, BURST_LEN beats per BURST_LEN+1 cycles
    clear();
    rd_en = 1'b1;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 8; b++) src[i].push_back(8'(8'hA0 + i * 16 + b));
    wait_writes(32, "t3");
    step(3);
    rd_en = 1'b0;
    for (int n = 0; n < 32; n++) chk_log("t3_data", n, 8'hA0 + ((n / 4) % 4) * 16 + (n / 16) * 4 + n % 4, (n / 4) % 4);
    if (wr_cyc.size() >= 32) chk("t3_throughput", wr_cyc[31] - wr_cyc[0], 38);
    // full stall: one beat fits, grant held while full, resumes after two reads
    pulse_reset();
    clear();
    for (int e = 0; e < 7; e++) fq.push_back(8'(8'hE0 + e));
    step(1);
    for (int b = 0; b < 3; b++) src[1].push_back(8'(8'h41 + b));
    wait_writes(1, "t4a");
    step(4);
    chk("t4_full", 32'(fifo_full), 1);
    chk("t4_wren_stall", 32'(fifo_wren), 0);
    chk("t4_one_beat", wr_log.size(), 1);
    chk("t4_hold", 32'(grant_vld), 1);
    rd_en = 1'b1;
    step(2);
    rd_en = 1'b0;
    wait_writes(3, "t4b");
    step(2);
    for (int i = 0; i < 3; i++) chk_log("t4_data", i, 8'h41 + i, 1);
    chk("t4_fifo_size", fq.size(), 8);
    for (int i = 0; i < 8 && i < fq.size(); i++) chk("t4_fifo", 32'(fq[i]), i < 5 ? 8'hE2 + i : 8'h41 + i - 5);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    step(3);
    chk("t4_released", 32'(grant_vld), 0);
`ifdef FIFO_ARB_STATS_EN
    chk("t4_stat_beats", stat_beats, 3);
    chk("t4_stat_stall", stat_stall, 5);
`endif
    // early drop by req 3 ends the burst and moves priority to 0
    clear();
    src[3].push_back(8'h51);
    src[3].push_back(8'h52);
    wait_writes(2, "t5a");
    src[1].push_back(8'h61);
    src[2].push_back(8'h62);
    wait_writes(4, "t5b");
    step(3);
    chk_log("t5_d0", 0, 8'h51, 3);
    chk_log("t5_d1", 1, 8'h52, 3);
    chk_log("t5_d2", 2, 8'h61, 1);
    chk_log("t5_d3", 3, 8'h62, 2);
    if (wr_cyc.size() >= 3) chk("t5_gap", wr_cyc[2] - wr_cyc[1], 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
